// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
// Optional RTC_TRANSFER_CMD_EN (used by rtc_bus_sequencer) appends a transfer command to write sweeps.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_ASSERT,
        ST_ADDR_GAP,
        ST_DATA_ASSERT,
        ST_DATA_GAP,
        ST_FINISH
    } state_t;

    typedef enum logic {
        SWP_RD,
        SWP_WR
    } sweep_t;

    localparam logic [7:0] XFER_CMD      = 8'hF1;
    localparam int         DEF_T_PULSE   = 4;
    localparam int         DEF_T_GAP     = 2;
    localparam int         DEF_N_REGS    = 7;
    localparam logic [7:0] DEF_BASE_ADDR = 8'h21;
    localparam int         TMR_W         = 8;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; 'last' marks the final cycle of the phase.
module rtc_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             last
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Walks the RTC time/date registers over the multiplexed AD bus for read or write sweeps.
// Define RTC_TRANSFER_CMD_EN to append an F1/F1 transfer-command bus cycle to every write sweep.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int         T_PULSE   = DEF_T_PULSE,
    parameter int         T_GAP     = DEF_T_GAP,
    parameter int         N_REGS    = DEF_N_REGS,
    parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Inicio_Lectura,
    input  logic       Inicio_Escritura,
    input  logic [7:0] wr_data,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [2:0] reg_idx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       BandFin
);

    state_t           state, state_nx;
    sweep_t           kind;
    logic             pend_wr, pend_rd;
    logic             start_wr, start_rd;
    logic             tmr_load, tmr_last;
    logic [TMR_W-1:0] tmr_val;
    logic             last_reg, sweep_done, xfer_act;
    logic [7:0]       addr_byte;

    rtc_phase_timer u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    assign last_reg = (reg_idx == 3'(N_REGS - 1));

`ifdef RTC_TRANSFER_CMD_EN
    logic xfer;
    always_ff @(posedge CLK) begin
        if (reset || start_wr || start_rd) begin
            xfer <= 1'b0;
        end else if (state == ST_DATA_GAP && tmr_last) begin
            xfer <= last_reg && (kind == SWP_WR) && !xfer;
        end
    end
    assign xfer_act   = xfer;
    // The transfer command is the extra bus cycle that closes a write sweep.
    assign sweep_done = xfer || (last_reg && kind == SWP_RD);
`else
    assign xfer_act   = 1'b0;
    assign sweep_done = last_reg;
`endif

    assign addr_byte = xfer_act ? XFER_CMD : 8'(BASE_ADDR + {5'b0, reg_idx});

    // Next state; FINISH arbitrates like IDLE so a pending sweep starts right after BandFin.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        start_wr = 1'b0;
        start_rd = 1'b0;
        case (state)
            ST_IDLE, ST_FINISH: begin
                state_nx = ST_IDLE;
                if (pend_wr || Inicio_Escritura) begin
                    start_wr = 1'b1;
                end else if (pend_rd || Inicio_Lectura) begin
                    start_rd = 1'b1;
                end
                if (start_wr || start_rd) begin
                    state_nx = ST_ADDR_ASSERT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_PULSE - 1);
                end
            end
            ST_ADDR_ASSERT: if (tmr_last) begin
                state_nx = ST_ADDR_GAP;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_GAP - 1);
            end
            ST_ADDR_GAP: if (tmr_last) begin
                state_nx = ST_DATA_ASSERT;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_PULSE - 1);
            end
            ST_DATA_ASSERT: if (tmr_last) begin
                state_nx = ST_DATA_GAP;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_GAP - 1);
            end
            ST_DATA_GAP: if (tmr_last) begin
                if (sweep_done) begin
                    state_nx = ST_FINISH;
                end else begin
                    state_nx = ST_ADDR_ASSERT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_PULSE - 1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_IDLE;
            kind     <= SWP_RD;
            pend_wr  <= 1'b0;
            pend_rd  <= 1'b0;
            reg_idx  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            pend_wr  <= (pend_wr || Inicio_Escritura) && !start_wr;
            pend_rd  <= (pend_rd || Inicio_Lectura) && !start_rd;
            rd_valid <= 1'b0;
            if (start_wr || start_rd) begin
                kind    <= start_wr ? SWP_WR : SWP_RD;
                reg_idx <= '0;
            end
            if (state == ST_DATA_ASSERT && kind == SWP_RD && tmr_last) begin
                rd_data  <= ad_in;
                rd_valid <= 1'b1;
            end
            if (state == ST_DATA_GAP && tmr_last) begin
                reg_idx <= (last_reg || xfer_act) ? 3'd0 : reg_idx + 3'd1;
            end
        end
    end

    always_comb begin
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        ad_n    = 1'b0;
        ad_oe   = 1'b0;
        ad_out  = 8'h00;
        busy    = 1'b0;
        BandFin = 1'b0;
        case (state)
            ST_ADDR_ASSERT: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_byte;
                busy   = 1'b1;
            end
            ST_ADDR_GAP: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_byte;
                busy   = 1'b1;
            end
            ST_DATA_ASSERT: begin
                cs_n = 1'b0;
                ad_n = 1'b1;
                busy = 1'b1;
                if (kind == SWP_WR) begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = xfer_act ? XFER_CMD : wr_data;
                end else begin
                    rd_n = 1'b0;
                end
            end
            ST_DATA_GAP: begin
                ad_n = 1'b1;
                busy = 1'b1;
            end
            ST_FINISH: BandFin = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: stimulus pushes expected bus activity, a monitor pops and compares.
module tb_rtc_bus_sequencer;

    localparam int T_PULSE = 4;
    localparam int N_REGS  = 7;
`ifdef RTC_TRANSFER_CMD_EN
    localparam int WR_LEN = (N_REGS + 1) * 12;
`else
    localparam int WR_LEN = N_REGS * 12;
`endif
    localparam int RD_LEN = N_REGS * 12;

    logic       CLK = 1'b0;
    logic       reset;
    logic       Inicio_Lectura, Inicio_Escritura;
    logic [7:0] wr_data, ad_in, ad_out, rd_data;
    logic       ad_oe, cs_n, ad_n, rd_n, wr_n, rd_valid, busy, BandFin;
    logic [2:0] reg_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_addr_q[$];
    logic [7:0]  exp_wdat_q[$];
    logic [10:0] exp_rd_q[$];
    logic [7:0]  exp_len_q[$];

    logic [7:0] rtc_mem[8];
    logic [7:0] lat_addr = 8'h21;

    rtc_bus_sequencer dut (
        .CLK(CLK), .reset(reset), .Inicio_Lectura(Inicio_Lectura),
        .Inicio_Escritura(Inicio_Escritura), .wr_data(wr_data), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n),
        .wr_n(wr_n), .reg_idx(reg_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .BandFin(BandFin)
    );

    // clock / reset
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // register bank and RTC models
    always_comb wr_data = 8'h30 + {5'b0, reg_idx};
    assign ad_in = rtc_mem[lat_addr[2:0] - 3'd1];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic underflow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, expected queue empty (cycle %0d)", name, cyc);
    endtask

    // driver tasks
    task automatic pulse_req(input logic wr, input logic rd);
        Inicio_Escritura = wr;
        Inicio_Lectura   = rd;
        @(posedge CLK); #1;
        Inicio_Escritura = 1'b0;
        Inicio_Lectura   = 1'b0;
    endtask

    task automatic push_write();
        for (int i = 0; i < N_REGS; i++) begin
            exp_addr_q.push_back(8'h21 + 8'(i));
            exp_wdat_q.push_back(8'h30 + 8'(i));
        end
`ifdef RTC_TRANSFER_CMD_EN
        exp_addr_q.push_back(8'hF1);
        exp_wdat_q.push_back(8'hF1);
`endif
        exp_len_q.push_back(8'(WR_LEN));
    endtask

    task automatic push_read();
        for (int i = 0; i < N_REGS; i++) begin
            exp_addr_q.push_back(8'h21 + 8'(i));
            exp_rd_q.push_back({3'(i), rtc_mem[i]});
        end
        exp_len_q.push_back(8'(RD_LEN));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge CLK);
        while ((busy || exp_len_q.size() != 0) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_timeout"}, int'(n >= 1000), 0);
    endtask

    task automatic wait_bandfin(output int lat, input int t0);
        int n = 0;
        @(negedge CLK);
        while (!BandFin && n < 300) begin
            @(negedge CLK);
            n++;
        end
        lat = cyc - t0;
        check("bandfin_seen", int'(BandFin), 1);
    endtask

    // monitor / scoreboard
    int   wlow = 0, rlow = 0, busy_cnt = 0;
    logic prev_wr_n = 1'b1;

    always @(negedge CLK) begin
        if (reset) begin
            wlow = 0; rlow = 0; busy_cnt = 0; prev_wr_n = 1'b1;
        end else begin
            if (!rd_n || !wr_n) check("strobe_overlap", int'(rd_n | wr_n), 1);
            if (!wr_n && prev_wr_n) begin
                if (!ad_n) begin
                    lat_addr = ad_out;
                    check("addr_cs_oe", int'({cs_n, ad_oe}), 1);
                    if (exp_addr_q.size() == 0) underflow("addr");
                    else check("addr", int'(ad_out), int'(exp_addr_q.pop_front()));
                end else begin
                    if (exp_wdat_q.size() == 0) underflow("wdata");
                    else check("wdata", int'(ad_out), int'(exp_wdat_q.pop_front()));
                end
            end
            if (!wr_n) wlow++;
            else if (wlow != 0) begin check("wr_pulse_len", wlow, T_PULSE); wlow = 0; end
            if (!rd_n) rlow++;
            else if (rlow != 0) begin check("rd_pulse_len", rlow, T_PULSE); rlow = 0; end
            if (rd_valid) begin
                if (exp_rd_q.size() == 0) underflow("rdata");
                else check("rdata", int'({reg_idx, rd_data}), int'(exp_rd_q.pop_front()));
            end
            if (busy) busy_cnt++;
            else begin
                if (BandFin) begin
                    if (exp_len_q.size() == 0) underflow("bandfin");
                    else check("sweep_len", busy_cnt, int'(exp_len_q.pop_front()));
                    check("bandfin_idx0", int'(reg_idx), 0);
                end
                busy_cnt = 0;
            end
            prev_wr_n = wr_n;
        end
    end

    initial begin
        int t0, lat;
        rtc_mem = '{8'h59, 8'h45, 8'h12, 8'h03, 8'h15, 8'h08, 8'h24, 8'h00};
        reset = 1'b1; Inicio_Lectura = 1'b0; Inicio_Escritura = 1'b0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        check("rst_strobes", int'({cs_n, rd_n, wr_n, ad_n, ad_oe}), 5'b11100);
        check("rst_ad_out", int'(ad_out), 0);
        check("rst_status", int'({reg_idx, rd_data, rd_valid, busy, BandFin}), 0);

        // write sweep, latency to BandFin
        @(posedge CLK); #1;
        push_write();
        t0 = cyc;
        pulse_req(1'b1, 1'b0);
        wait_bandfin(lat, t0);
        check("wr_bandfin_cycle", lat, WR_LEN + 1);
        wait_done("write");

        // read sweep
        @(posedge CLK); #1;
        push_read();
        pulse_req(1'b0, 1'b1);
        wait_done("read");

        // simultaneous requests: write first, read right after BandFin
        @(posedge CLK); #1;
        push_write();
        push_read();
        t0 = cyc;
        pulse_req(1'b1, 1'b1);
        wait_bandfin(lat, t0);
        @(negedge CLK);
        check("chain_busy_cs", int'({busy, cs_n}), 2'b10);
        wait_done("both");

        // read requested in the middle of a write sweep
        @(posedge CLK); #1;
        push_write();
        push_read();
        pulse_req(1'b1, 1'b0);
        repeat (30) @(posedge CLK);
        #1 pulse_req(1'b0, 1'b1);
        wait_done("mid");

        // reset during a sweep abandons it without BandFin
        @(posedge CLK); #1;
        push_write();
        t0 = cyc;
        pulse_req(1'b1, 1'b0);
        while (cyc < t0 + 20) @(posedge CLK);
        #1 reset = 1'b1;
        @(posedge CLK); #1 reset = 1'b0;
        @(negedge CLK);
        check("abort_strobes", int'({cs_n, rd_n, wr_n}), 3'b111);
        check("abort_busy_idx", int'({busy, BandFin, reg_idx}), 0);
        exp_addr_q.delete(); exp_wdat_q.delete(); exp_rd_q.delete(); exp_len_q.delete();
        repeat (10) @(negedge CLK);

        // fresh read after the abort starts from register 0
        @(posedge CLK); #1;
        push_read();
        pulse_req(1'b0, 1'b1);
        wait_done("after_abort");

        repeat (5) @(negedge CLK);
        check("left_addr", exp_addr_q.size(), 0);
        check("left_wdata", exp_wdat_q.size(), 0);
        check("left_rdata", exp_rd_q.size(), 0);
        check("left_len", exp_len_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
